// File: rtl/darkriscv_mon_pkg.sv
// Shared definitions for the memory access monitor: opcodes, fault codes,
// FSM states and the pipeline record passed from classify to update stage.
package darkriscv_mon_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [2:0] F3_WORD  = 3'b010;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_LOAD     = 2'b01,
        ERR_STORE    = 2'b10,
        ERR_MISALIGN = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_FAULT    = 2'b10
    } state_e;

    typedef struct packed {
        logic        valid;
        logic        is_store;
        err_code_e   code;
        logic [31:0] addr;
    } access_s;

    // Fault code for an unmapped or permission-denied access of the given kind
    function automatic err_code_e denied_code(input logic is_store);
        return is_store ? ERR_STORE : ERR_LOAD;
    endfunction

endpackage

// File: rtl/mem_region_match.sv
// Combinational check of one word address against an inclusive region.
module mem_region_match
    import darkriscv_mon_pkg::*;
#(
    parameter logic [31:0] BASE  = '0,
    parameter logic [31:0] LIMIT = '0,
    parameter logic [1:0]  PERM  = '0
) (
    input  logic [31:0] waddr,
    output logic        hit,
    output logic [1:0]  perm
);

    logic [32:0] lo_diff;
    logic [32:0] hi_diff;

    // Bounds tested via the borrow of a 33-bit subtraction so a zero base
    // does not degenerate into a constant comparison
    always_comb begin
        lo_diff = {1'b0, waddr} - {1'b0, BASE};
        hi_diff = {1'b0, LIMIT} - {1'b0, waddr};
        hit     = !lo_diff[32] && !hi_diff[32];
        perm    = PERM;
    end

endmodule

// File: rtl/mem_access_checker.sv
// Load/store access checker: classifies the execute-stage instruction,
// matches its word address against the region table, and tracks faults
// and access counters one cycle later.
module mem_access_checker
    import darkriscv_mon_pkg::*;
#(
    parameter int unsigned            NREGIONS  = 2,
    parameter int unsigned            CNT_W     = 16,
    parameter logic [NREGIONS*32-1:0] REG_BASE  = {32'd512, 32'd0},
    parameter logic [NREGIONS*32-1:0] REG_LIMIT = {32'd1023, 32'd511},
    parameter logic [NREGIONS*2-1:0]  REG_PERM  = {2'b11, 2'b00}
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             EN,
    input  logic             CLR,
    input  logic             HLT,
    input  logic [31:0]      XIDATA,
    input  logic [31:0]      DADDR,
    output logic             ERR,
    output logic [1:0]       ERR_CODE,
    output logic [31:0]      ERR_ADDR,
    output logic [CNT_W-1:0] LD_CNT,
    output logic [CNT_W-1:0] ST_CNT,
    output logic [CNT_W-1:0] VIOL_CNT,
    output logic [1:0]       STATE
);

    logic [31:0]           waddr;
    logic [NREGIONS-1:0]   hit;
    logic [NREGIONS*2-1:0] perm;

    logic        is_load;
    logic        is_store;
    logic        match_found;
    logic [1:0]  match_perm;
    logic        allowed;
    err_code_e   cls_code;

    state_e            state_q, state_d;
    access_s           pipe_q, pipe_d;
    err_code_e         err_code_q, err_code_d;
    logic [31:0]       err_addr_q, err_addr_d;
    logic [CNT_W-1:0]  ld_q, ld_d, st_q, st_d, viol_q, viol_d;
    logic [CNT_W-1:0]  ld_base, st_base, viol_base;
    logic              out_viol;

    assign waddr = {2'b00, DADDR[31:2]};

    for (genvar i = 0; i < NREGIONS; i++) begin : g_region
        mem_region_match #(
            .BASE  (REG_BASE[i*32 +: 32]),
            .LIMIT (REG_LIMIT[i*32 +: 32]),
            .PERM  (REG_PERM[i*2 +: 2])
        ) u_match (
            .waddr (waddr),
            .hit   (hit[i]),
            .perm  (perm[i*2 +: 2])
        );
    end

    // Classify the current instruction: kind, lowest matching region, fault code
    always_comb begin
        is_load     = (XIDATA[6:0] == OP_LOAD);
        is_store    = (XIDATA[6:0] == OP_STORE);
        match_found = 1'b0;
        match_perm  = '0;
        for (int unsigned i = 0; i < NREGIONS; i++) begin
            if (hit[i] && !match_found) begin
                match_found = 1'b1;
                match_perm  = perm[i*2 +: 2];
            end
        end
        allowed = match_found && (is_store ? match_perm[1] : match_perm[0]);
        if (DADDR[1:0] != 2'b00 && XIDATA[14:12] == F3_WORD) begin
            cls_code = ERR_MISALIGN;
        end else if (!allowed) begin
            cls_code = denied_code(is_store);
        end else begin
            cls_code = ERR_NONE;
        end
    end

    // Update stage: counters, capture and FSM act on the registered access
    always_comb begin
        out_viol  = pipe_q.valid && (pipe_q.code != ERR_NONE);

        // CLR clears first; an access arriving in the same cycle is then
        // applied on top, so a coincident violation survives the clear
        ld_base   = CLR ? '0 : ld_q;
        st_base   = CLR ? '0 : st_q;
        viol_base = CLR ? '0 : viol_q;

        ld_d   = ld_base;
        st_d   = st_base;
        viol_d = viol_base;
        if (pipe_q.valid && !pipe_q.is_store && ld_base != '1) begin
            ld_d = ld_base + CNT_W'(1);
        end
        if (pipe_q.valid && pipe_q.is_store && st_base != '1) begin
            st_d = st_base + CNT_W'(1);
        end
        if (out_viol && viol_base != '1) begin
            viol_d = viol_base + CNT_W'(1);
        end

        err_code_d = CLR ? ERR_NONE : err_code_q;
        err_addr_d = CLR ? '0 : err_addr_q;
        if (out_viol && (state_q == ST_ARMED || CLR)) begin
            err_code_d = pipe_q.code;
            err_addr_d = pipe_q.addr;
        end

        state_d = state_q;
        case (state_q)
            ST_DISARMED: if (EN) state_d = ST_ARMED;
            ST_ARMED: begin
                if (out_viol)  state_d = ST_FAULT;
                else if (!EN)  state_d = ST_DISARMED;
            end
            ST_FAULT: begin
                if (out_viol)  state_d = ST_FAULT;
                else if (CLR)  state_d = EN ? ST_ARMED : ST_DISARMED;
            end
            default: state_d = ST_DISARMED;
        endcase

        // Nothing is captured while disarmed or when about to disarm
        pipe_d.valid    = (is_load || is_store) && !HLT &&
                          (state_q != ST_DISARMED) && (state_d != ST_DISARMED);
        pipe_d.is_store = is_store;
        pipe_d.code     = cls_code;
        pipe_d.addr     = DADDR;
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q    <= ST_DISARMED;
            pipe_q     <= '0;
            err_code_q <= ERR_NONE;
            err_addr_q <= '0;
            ld_q       <= '0;
            st_q       <= '0;
            viol_q     <= '0;
        end else begin
            state_q    <= state_d;
            pipe_q     <= pipe_d;
            err_code_q <= err_code_d;
            err_addr_q <= err_addr_d;
            ld_q       <= ld_d;
            st_q       <= st_d;
            viol_q     <= viol_d;
        end
    end

    assign ERR      = (state_q == ST_FAULT);
    assign ERR_CODE = err_code_q;
    assign ERR_ADDR = err_addr_q;
    assign LD_CNT   = ld_q;
    assign ST_CNT   = st_q;
    assign VIOL_CNT = viol_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_mem_access_checker.sv
// Bench for mem_access_checker: two instances (16-bit and 4-bit counters)
// share stimulus; directed table, saturation/reset sequence, random run.
module tb_mem_access_checker;

    localparam logic [31:0] LW  = 32'h00002003;
    localparam logic [31:0] SW  = 32'h00002023;
    localparam logic [31:0] LB  = 32'h00000003;
    localparam logic [31:0] SH  = 32'h00001023;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RES, EN, CLR, HLT;
    logic [31:0] XIDATA, DADDR;

    logic        a_err, b_err;
    logic [1:0]  a_code, b_code, a_state, b_state;
    logic [31:0] a_addr, b_addr;
    logic [15:0] a_ld, a_st, a_vl;
    logic [3:0]  b_ld, b_st, b_vl;

    mem_access_checker #(.NREGIONS(2), .CNT_W(16)) dut_a (
        .CLK(CLK), .RES(RES), .EN(EN), .CLR(CLR), .HLT(HLT),
        .XIDATA(XIDATA), .DADDR(DADDR),
        .ERR(a_err), .ERR_CODE(a_code), .ERR_ADDR(a_addr),
        .LD_CNT(a_ld), .ST_CNT(a_st), .VIOL_CNT(a_vl), .STATE(a_state)
    );

    mem_access_checker #(.NREGIONS(2), .CNT_W(4)) dut_b (
        .CLK(CLK), .RES(RES), .EN(EN), .CLR(CLR), .HLT(HLT),
        .XIDATA(XIDATA), .DADDR(DADDR),
        .ERR(b_err), .ERR_CODE(b_code), .ERR_ADDR(b_addr),
        .LD_CNT(b_ld), .ST_CNT(b_st), .VIOL_CNT(b_vl), .STATE(b_state)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Region table as plain lists: words [base..limit], perm bit0 load / bit1 store
    int unsigned rb[2] = '{0, 512};
    int unsigned rl[2] = '{511, 1023};
    int unsigned rp[2] = '{0, 3};

    int          m_state, m_ld, m_st, m_vl, m_code;
    logic [31:0] m_addr;
    bit          p_v, p_st;
    int          p_code;
    logic [31:0] p_addr;

    function automatic int rule_code(input bit st, input logic [31:0] xi, input logic [31:0] da);
        longint unsigned w = longint'(da) / 4;
        logic [2:0] f3 = xi[14:12];
        if ((da % 4) != 0 && f3 == 3'b010) return 3;
        for (int r = 0; r < 2; r++) begin
            if (w >= rb[r] && w <= rl[r]) begin
                if (((rp[r] >> (st ? 1 : 0)) & 1) == 1) return 0;
                return st ? 2 : 1;
            end
        end
        return st ? 2 : 1;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_edge();
        bit viol, is_ld, is_st;
        int nxt;
        if (RES) begin
            m_state = 0; m_ld = 0; m_st = 0; m_vl = 0; m_code = 0; m_addr = 0;
            p_v = 0;
        end else begin
            viol = p_v && (p_code != 0);
            if (CLR) begin
                m_ld = 0; m_st = 0; m_vl = 0; m_code = 0; m_addr = 0;
            end
            if (p_v) begin
                if (p_st) m_st++; else m_ld++;
                if (viol) m_vl++;
            end
            if (viol && (m_state == 1 || CLR)) begin
                m_code = p_code;
                m_addr = p_addr;
            end
            nxt = m_state;
            if (m_state == 0 && EN) nxt = 1;
            else if (m_state == 1) nxt = viol ? 2 : (EN ? 1 : 0);
            else if (m_state == 2 && !viol && CLR) nxt = EN ? 1 : 0;
            is_ld = (XIDATA[6:0] == 7'b0000011);
            is_st = (XIDATA[6:0] == 7'b0100011);
            p_v    = (is_ld || is_st) && !HLT && m_state != 0 && nxt != 0;
            p_st   = is_st;
            p_code = rule_code(is_st, XIDATA, DADDR);
            p_addr = DADDR;
            m_state = nxt;
        end
    endtask

    task automatic compare_model(input int cyc);
        string t = $sformatf("@%0d", cyc);
        check({"a.state", t}, a_state, m_state);
        check({"a.err", t},   a_err, (m_state == 2));
        check({"a.code", t},  a_code, m_code);
        check({"a.addr", t},  a_addr, m_addr);
        check({"a.ld", t},    a_ld, sat(m_ld, 65535));
        check({"a.st", t},    a_st, sat(m_st, 65535));
        check({"a.viol", t},  a_vl, sat(m_vl, 65535));
        check({"b.state", t}, b_state, m_state);
        check({"b.err", t},   b_err, (m_state == 2));
        check({"b.code", t},  b_code, m_code);
        check({"b.addr", t},  b_addr, m_addr);
        check({"b.ld", t},    b_ld, sat(m_ld, 15));
        check({"b.st", t},    b_st, sat(m_st, 15));
        check({"b.viol", t},  b_vl, sat(m_vl, 15));
    endtask

    int cycle = 0;

    task automatic step(input bit r, input bit e, input bit c, input bit h,
                        input logic [31:0] xi, input logic [31:0] da);
        RES = r; EN = e; CLR = c; HLT = h; XIDATA = xi; DADDR = da;
        @(posedge CLK);
        model_edge();
        #1;
        cycle++;
        compare_model(cycle);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          res, en, clr, hlt;
        logic [31:0] xi, da;
        int          st, code;
        logic [31:0] addr;
        int          ld, stc, vl;
    } vec_t;

    vec_t tbl[$];

    task automatic tv(input bit r, input bit e, input bit c, input bit h,
                      input logic [31:0] xi, input logic [31:0] da,
                      input int st, input int code, input logic [31:0] addr,
                      input int ld, input int stc, input int vl);
        vec_t v;
        v.res = r; v.en = e; v.clr = c; v.hlt = h; v.xi = xi; v.da = da;
        v.st = st; v.code = code; v.addr = addr; v.ld = ld; v.stc = stc; v.vl = vl;
        tbl.push_back(v);
    endtask

    initial begin
        RES = 1; EN = 0; CLR = 0; HLT = 0; XIDATA = NOP; DADDR = '0;

        //  res en clr hlt  xi   daddr       state code addr     ld st vl
        tv(1, 0, 0, 0, NOP, 32'h0,      0, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 0, NOP, 32'h0,      1, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 0, LW,  32'h800,    1, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 0, NOP, 32'h0,      1, 0, 32'h0,    1, 0, 0);
        tv(0, 1, 0, 0, LW,  32'h7FC,    1, 0, 32'h0,    1, 0, 0);
        tv(0, 1, 0, 0, NOP, 32'h0,      2, 1, 32'h7FC,  2, 0, 1);
        tv(0, 1, 1, 0, NOP, 32'h0,      1, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 0, SW,  32'h1000,   1, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 0, LB,  32'h0,      2, 2, 32'h1000, 0, 1, 1);
        tv(0, 1, 0, 0, NOP, 32'h0,      2, 2, 32'h1000, 1, 1, 2);
        tv(0, 1, 1, 0, NOP, 32'h0,      1, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 0, LW,  32'h802,    1, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 0, NOP, 32'h0,      2, 3, 32'h802,  1, 0, 1);
        tv(0, 1, 1, 0, NOP, 32'h0,      1, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 1, LW,  32'h800,    1, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 1, LW,  32'h800,    1, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 1, LW,  32'h800,    1, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 0, LW,  32'h800,    1, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 0, NOP, 32'h0,      1, 0, 32'h0,    1, 0, 0);
        tv(0, 1, 0, 0, NOP, 32'h0,      1, 0, 32'h0,    1, 0, 0);
        tv(0, 1, 0, 0, LW,  32'h7FC,    1, 0, 32'h0,    1, 0, 0);
        tv(0, 1, 0, 0, SW,  32'h2000,   2, 1, 32'h7FC,  2, 0, 1);
        tv(0, 1, 1, 0, NOP, 32'h0,      2, 2, 32'h2000, 0, 1, 1);
        tv(0, 0, 0, 0, NOP, 32'h0,      2, 2, 32'h2000, 0, 1, 1);
        tv(0, 0, 1, 0, NOP, 32'h0,      0, 0, 32'h0,    0, 0, 0);
        tv(0, 0, 0, 0, LW,  32'h800,    0, 0, 32'h0,    0, 0, 0);
        tv(0, 0, 0, 0, NOP, 32'h0,      0, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 0, NOP, 32'h0,      1, 0, 32'h0,    0, 0, 0);
        tv(0, 1, 0, 0, LW,  32'h800,    1, 0, 32'h0,    0, 0, 0);
        tv(0, 0, 0, 0, LW,  32'h800,    0, 0, 32'h0,    1, 0, 0);
        tv(0, 0, 0, 0, NOP, 32'h0,      0, 0, 32'h0,    1, 0, 0);
        tv(0, 1, 0, 0, NOP, 32'h0,      1, 0, 32'h0,    1, 0, 0);
        tv(0, 1, 0, 0, SW,  32'h900,    1, 0, 32'h0,    1, 0, 0);
        tv(0, 1, 0, 0, NOP, 32'h0,      1, 0, 32'h0,    1, 1, 0);

        foreach (tbl[i]) begin
            string t = $sformatf("tbl%0d", i);
            step(tbl[i].res, tbl[i].en, tbl[i].clr, tbl[i].hlt, tbl[i].xi, tbl[i].da);
            check({t, ".state"}, a_state, tbl[i].st);
            check({t, ".err"},   a_err, (tbl[i].st == 2));
            check({t, ".code"},  a_code, tbl[i].code);
            check({t, ".addr"},  a_addr, tbl[i].addr);
            check({t, ".ld"},    a_ld, tbl[i].ld);
            check({t, ".st"},    a_st, tbl[i].stc);
            check({t, ".viol"},  a_vl, tbl[i].vl);
        end

        // Saturation of the 4-bit instance, then reset out of FAULT
        step(1, 0, 0, 0, NOP, 32'h0);
        step(0, 1, 0, 0, NOP, 32'h0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, LW, 32'h800);
        step(0, 1, 0, 0, LW, 32'h7FC);
        step(0, 1, 0, 0, NOP, 32'h0);
        step(0, 1, 0, 0, NOP, 32'h0);
        check("sat.b.ld", b_ld, 15);
        check("sat.a.ld", a_ld, 21);
        check("sat.b.state", b_state, 2);
        step(1, 1, 0, 0, LW, 32'h7FC);
        check("rst.b.state", b_state, 0);
        check("rst.b.err", b_err, 0);
        check("rst.b.code", b_code, 0);
        check("rst.b.addr", b_addr, 0);
        check("rst.b.ld", b_ld, 0);
        check("rst.b.viol", b_vl, 0);
        step(0, 0, 0, 0, NOP, 32'h0);
        check("rst.b.ld2", b_ld, 0);

        // Random run against the model
        for (int i = 0; i < 2500; i++) begin
            logic [31:0] xi, da;
            case ($urandom_range(0, 6))
                0: xi = LW;
                1: xi = SW;
                2: xi = LB;
                3: xi = SH;
                4: xi = NOP;
                5: xi = $urandom();
                default: xi = LW | ($urandom() & 32'hFFF00F80);
            endcase
            case ($urandom_range(0, 3))
                0: da = $urandom_range(0, 4500);
                1: da = $urandom_range(0, 1200) * 4;
                2: da = $urandom();
                default: da = 32'h800 + $urandom_range(0, 3);
            endcase
            step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, xi, da);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
